// File: rtl/pipe_skid_pkg.sv
// Shared types and constants for the pipe_skid elastic stage.
package pipe_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam int STALL_W = 16;

endpackage

// File: rtl/pipe_skid_if.sv
// Valid/ready handshake bundle: upstream (i_valid/o_ready/i_data) and downstream (o_valid/i_ready/o_data).
interface pipe_skid_if #(
    parameter int p_width = 32
);
    logic               i_valid;
    logic               o_ready;
    logic [p_width-1:0] i_data;
    logic               o_valid;
    logic               i_ready;
    logic [p_width-1:0] o_data;

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data
    );

    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Enable-loaded data register, asynchronously cleared to zero.
module pipe_skid_reg #(
    parameter int p_width = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic [p_width-1:0] i_d,
    output logic [p_width-1:0] o_q
);
    logic [p_width-1:0] data_q;
    logic [p_width-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (i_en) data_d = i_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) data_q <= '0;
        else          data_q <= data_d;
    end

    assign o_q = data_q;
endmodule

// File: rtl/pipe_skid.sv
// Full-throughput skid-buffer pipeline stage (main + skid register).
// Optional saturating stall counter enabled by PIPE_SKID_STALL_COUNT_EN.
module pipe_skid
    import pipe_skid_pkg::*;
#(
    parameter int p_width = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
`ifdef PIPE_SKID_STALL_COUNT_EN
    output logic [STALL_W-1:0] o_stall_count,
`endif
    pipe_skid_if.slave         bus
);
    state_e             state_q, state_d;
    logic               main_en, skid_en, main_from_skid;
    logic [p_width-1:0] main_d, main_q, skid_q;
    logic               up_xfer, dn_xfer;

    // Ready depends on state and reset only, so no comb path from i_ready/i_valid.
    assign bus.o_ready = i_rst_n && (state_q != FULL);
    assign bus.o_valid = (state_q != EMPTY);
    assign bus.o_data  = main_q;

    assign up_xfer = bus.i_valid && bus.o_ready;
    assign dn_xfer = bus.o_valid && bus.i_ready;

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (up_xfer) begin
                    main_en = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (up_xfer && dn_xfer) begin
                    main_en = 1'b1;
                end else if (up_xfer) begin
                    skid_en = 1'b1;
                    state_d = FULL;
                end else if (dn_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (dn_xfer) begin
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign main_d = main_from_skid ? skid_q : bus.i_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= EMPTY;
        else          state_q <= state_d;
    end

    pipe_skid_reg #(.p_width(p_width)) u_main (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (main_en),
        .i_d     (main_d),
        .o_q     (main_q)
    );

    pipe_skid_reg #(.p_width(p_width)) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (skid_en),
        .i_d     (bus.i_data),
        .o_q     (skid_q)
    );

`ifdef PIPE_SKID_STALL_COUNT_EN
    logic [STALL_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (bus.o_valid && !bus.i_ready && (stall_q != '1))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) stall_q <= '0;
        else          stall_q <= stall_d;
    end

    assign o_stall_count = stall_q;
`endif
endmodule

// File: tb/tb_pipe_skid.sv
// Self-checking bench for pipe_skid: queue-based capacity-2 model plus directed literal checks.
module tb_pipe_skid;
    localparam int W = 32;

    logic i_clk;
    logic i_rst_n;

    pipe_skid_if #(.p_width(W)) bus ();

`ifdef PIPE_SKID_STALL_COUNT_EN
    logic [15:0] o_stall_count;
`endif

    pipe_skid #(.p_width(W)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
`ifdef PIPE_SKID_STALL_COUNT_EN
        .o_stall_count (o_stall_count),
`endif
        .bus           (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage behaves as a FIFO of depth 2 whose head is visible downstream.
    logic [W-1:0] mq[$];
    int unsigned  mstall;
    logic [W-1:0] out_log[$];

    always @(negedge i_rst_n) begin
        mq.delete();
        mstall = 0;
    end

    always @(posedge i_clk) begin
        if (i_rst_n) begin
            bit up, dn;
            up = bus.i_valid && (mq.size() < 2);
            dn = (mq.size() > 0) && bus.i_ready;
            if ((mq.size() > 0) && !bus.i_ready && mstall < 16'hFFFF) mstall++;
            if (dn) out_log.push_back(mq.pop_front());
            if (up) mq.push_back(bus.i_data);
        end
    end

    always @(negedge i_clk) begin
        check("m_valid", bus.o_valid, (mq.size() > 0));
        check("m_ready", bus.o_ready, (i_rst_n && mq.size() < 2));
        if (mq.size() > 0) check("m_data", bus.o_data, mq[0]);
`ifdef PIPE_SKID_STALL_COUNT_EN
        check("m_stall", o_stall_count, mstall);
`endif
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
        bus.i_valid = v;
        bus.i_data  = d;
        bus.i_ready = r;
    endtask

    logic [W-1:0] sent[$];
    int           base;
    bit           saw_full;

    initial begin
        i_rst_n = 1'b0;
        drive(1'b0, '0, 1'b0);
        #1;
        check("rst_ready", bus.o_ready, 1'b0);
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_data",  bus.o_data,  '0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check("rel_ready", bus.o_ready, 1'b1);
        check("rel_valid", bus.o_valid, 1'b0);
        check("rel_data",  bus.o_data,  '0);
        step();

        // Streaming
        drive(1'b1, 32'h11, 1'b1); step();
        check("st1_data", bus.o_data, 32'h11); check("st1_ready", bus.o_ready, 1'b1);
        drive(1'b1, 32'h22, 1'b1); step();
        check("st2_data", bus.o_data, 32'h22); check("st2_ready", bus.o_ready, 1'b1);
        drive(1'b1, 32'h33, 1'b1); step();
        check("st3_data", bus.o_data, 32'h33); check("st3_ready", bus.o_ready, 1'b1);
        drive(1'b0, '0, 1'b1); step();
        check("st_end_valid", bus.o_valid, 1'b0);

        // Backpressure
        drive(1'b1, 32'hA, 1'b0); step();
        check("bp_a_data", bus.o_data, 32'hA);
        drive(1'b1, 32'hB, 1'b0); step();
        check("bp_full_ready", bus.o_ready, 1'b0);
        check("bp_full_data",  bus.o_data,  32'hA);
        drive(1'b1, 32'hC, 1'b0); step();
        check("bp_c_ignored_data",  bus.o_data,  32'hA);
        check("bp_c_ignored_ready", bus.o_ready, 1'b0);
        drive(1'b0, 32'hC, 1'b1); step();
        check("bp_drain_b_valid", bus.o_valid, 1'b1);
        check("bp_drain_b_data",  bus.o_data,  32'hB);
        step();
        check("bp_drain_empty", bus.o_valid, 1'b0);

        // Drain/fill: 100 random words with simultaneous transfers
        base = out_log.size();
        sent.delete();
        saw_full = 1'b0;
        for (int i = 0; i < 100; i++) begin
            logic [W-1:0] w;
            w = $urandom;
            sent.push_back(w);
            drive(1'b1, w, 1'b1);
            step();
            if (!bus.o_ready) saw_full = 1'b1;
        end
        drive(1'b0, '0, 1'b1);
        step(); step();
        check("df_never_full", saw_full, 1'b0);
        check("df_count", out_log.size() - base, 100);
        for (int i = 0; i < 100; i++)
            if (base + i < out_log.size() && out_log[base+i] !== sent[i])
                check("df_order", out_log[base+i], sent[i]);
        check("df_first", out_log[base], sent[0]);

        // Reset mid-operation from FULL
        drive(1'b1, 32'h5A, 1'b0); step();
        drive(1'b1, 32'h6B, 1'b0); step();
        check("mr_full_ready", bus.o_ready, 1'b0);
        drive(1'b0, '0, 1'b1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("mr_valid", bus.o_valid, 1'b0);
        check("mr_data",  bus.o_data,  '0);
        check("mr_ready", bus.o_ready, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) begin
            step();
            check("mr_no_stale", bus.o_valid, 1'b0);
        end

`ifdef PIPE_SKID_STALL_COUNT_EN
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("sc_rst", o_stall_count, 16'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        drive(1'b1, 32'h77, 1'b1); step();
        drive(1'b0, '0, 1'b0);
        repeat (5) step();
        check("sc_five", o_stall_count, 16'd5);
        repeat (70000) @(posedge i_clk);
        #1;
        check("sc_sat", o_stall_count, 16'hFFFF);
        drive(1'b0, '0, 1'b1); step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule
